student_tdm_clock_gen: RTL and testbench
========================================

Name: student_tdm_clock_gen

Overview:
- Parametrised successor to the fixed two-channel I2S clock generator that paces the parallel FIR sample stream.
- Generates MCLK, BCLK and frame-sync (LRCLK) for 2-slot I2S or N-slot TDM frames, all from one system clock.
- Emits single-cycle edge strobes plus slot and bit indices, so downstream FIR/serialiser logic can launch valid_strobe_in per slot.
- Supports a graceful enable/disable that always stops on a frame boundary.

Parameters:
DATA_SIZE, 16, bits per slot (>=2)
NUM_SLOTS, 2, slots per frame (>=2); 2 = I2S mode, >2 = TDM mode
MCLK_DIV, 4, clk_i cycles per AC_MCLK period (even, >=2)
BCLK_DIV, 2, AC_MCLK periods per AC_BCLK period (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-high
en_i  in  1  run request, level-sensitive
AC_MCLK  out  1  master clock, 50% duty
AC_BCLK  out  1  bit clock
BCLK_Rise  out  1  one-cycle strobe, AC_BCLK rose this cycle
BCLK_Fall  out  1  one-cycle strobe, AC_BCLK fell this cycle
AC_LRCLK  out  1  frame sync
LRCLK_Rise  out  1  one-cycle strobe, AC_LRCLK rose this cycle
LRCLK_Fall  out  1  one-cycle strobe, AC_LRCLK fell this cycle
frame_start_o  out  1  one-cycle strobe on the BCLK_Fall that begins slot 0, bit 0
slot_idx_o  out  $clog2(NUM_SLOTS)  current slot
bit_idx_o  out  $clog2(DATA_SIZE)  current bit in slot (0 = MSB)
busy_o  out  1  high in RUN or STOP

Behaviour:
- Reset: rst_i high at a clk_i edge forces every output to 0, counters to 0 and state to IDLE on that edge, including mid-frame.
- Derived constant: BCLK_HALF = (MCLK_DIV/2)*BCLK_DIV clk_i cycles.
- FSM states: IDLE, RUN, STOP.
  - IDLE->RUN: en_i=1.
  - RUN->STOP: en_i=0.
  - STOP->RUN: en_i=1, with no gap and no counter reset.
  - STOP->IDLE: at the frame-ending BCLK_Fall.
- IDLE: all clocks held low, no strobes, busy_o=0.
- MCLK: toggles every MCLK_DIV/2 cycles while busy_o=1. Counter restarts at 0 on entry to RUN from IDLE.
- BCLK: a divider counts 0..BCLK_HALF-1. At terminal count AC_BCLK toggles, and the matching Rise/Fall strobe is high in the same cycle the new level is visible (both registered on the same edge).
  - The first BCLK_Rise comes BCLK_HALF cycles after busy_o rises.
  - The first BCLK_Fall comes 2*BCLK_HALF cycles after busy_o rises and carries frame_start_o.
- Indices: update on BCLK_Fall only.
  - bit_idx_o increments and wraps DATA_SIZE-1->0.
  - On that wrap slot_idx_o increments and wraps NUM_SLOTS-1->0.
  - The slot wrap asserts frame_start_o.
  - The first frame after IDLE starts at slot 0, bit 0.
- LRCLK, I2S mode (NUM_SLOTS==2): AC_LRCLK = slot_idx_o[0], left-justified, transitions coincide with BCLK_Fall.
- LRCLK, TDM mode: AC_LRCLK is high for exactly one BCLK period, from the frame_start BCLK_Fall to the next BCLK_Fall.
- LRCLK strobes: LRCLK_Rise and LRCLK_Fall coincide with the level change.
- STOP: clocks continue until the BCLK_Fall that would start a new frame.
  - On that edge: AC_BCLK=0, AC_LRCLK=0, indices=0, no frame_start_o or LRCLK strobe, state IDLE, busy_o=0.
  - MCLK is forced low on the same edge.
- Simultaneous en_i deassert and frame-ending BCLK_Fall in RUN: that frame boundary is not the stop point. The block enters STOP and finishes one more full frame.
- Latency: frame_start_o to next frame_start_o = 2*BCLK_HALF*DATA_SIZE*NUM_SLOTS cycles, exact, with no jitter.

Optional Feature:
- Macro: STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt_o [31:0], reset 0.
  - Increments on each frame_start_o and wraps 0xFFFFFFFF->0.
  - Retains its value through IDLE; cleared only by rst_i.
- Undefined: the port and the counter are absent.

Decomposition:
- Package student_tdm_clock_gen_pkg holds:
  - fsm state typedef (IDLE/RUN/STOP);
  - function computing BCLK_HALF;
  - localparam widths for slot and bit indices.
- One sub-module, student_clk_div_strobe: parametrised divider producing a toggled level plus rise/fall strobes with sync clear and enable. Instantiated for MCLK and BCLK.

Test Plan:
1. Defaults; rst_i 4 cycles, en_i=1 → first BCLK_Rise 4 cycles after busy_o, first BCLK_Fall and frame_start_o at 8; MCLK period 4; frame_start period 256 cycles.
2. Defaults, 3 frames → AC_LRCLK low for bit_idx 0..15 of slot 0, high for slot 1; LRCLK_Rise at cycle 128 after frame_start, LRCLK_Fall at the next frame_start.
3. NUM_SLOTS=8, DATA_SIZE=32, MCLK_DIV=2, BCLK_DIV=1 → BCLK period 2; AC_LRCLK high exactly 2 cycles per frame; slot_idx_o cycles 0..7; frame period 512.
4. Defaults; drop en_i at slot 0 bit 5 → clocks continue to end of that frame, then all outputs 0, busy_o=0, no extra frame_start_o; re-raising en_i during STOP gives uninterrupted frames.
5. Assert rst_i mid-slot 1 → all outputs 0 on the next edge; after release with en_i=1, restart timing identical to scenario 1.
6. With STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN defined → frame_cnt_o = 5 after 5 frame_start_o; unchanged across stop/restart; 0 after rst_i.

Source files
------------

// File: rtl/student_tdm_clock_gen_pkg.sv
// Shared types and sizing helpers for the I2S/TDM clock generator.
package student_tdm_clock_gen_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_e;

   localparam int DEF_SLOT_W = $clog2(2);
   localparam int DEF_BIT_W  = $clog2(16);

   // clk_i cycles per half BCLK period
   function automatic int bclk_half(input int mclk_div, input int bclk_div);
      return (mclk_div / 2) * bclk_div;
   endfunction

   // Counter width that stays legal for a modulus of 1
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/student_clk_div_strobe.sv
// Half-period divider: toggles level_o every HALF enabled cycles and flags the
// edge with a rise/fall strobe registered on the same clock edge as the level.
module student_clk_div_strobe
   import student_tdm_clock_gen_pkg::*;
#(
   parameter int HALF = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int            CW   = idx_w(HALF);
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   assign tc_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (clr_i) begin
         cnt_d   = '0;
         level_d = 1'b0;
      end else if (en_i) begin
         if (tc_o) begin
            cnt_d   = '0;
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/student_tdm_clock_gen.sv
// MCLK/BCLK/LRCLK generator for I2S (2 slots) or TDM (>2 slots) frames.
// Optional frame counter port enabled by STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN.
module student_tdm_clock_gen
   import student_tdm_clock_gen_pkg::*;
#(
   parameter int DATA_SIZE = 16,
   parameter int NUM_SLOTS = 2,
   parameter int MCLK_DIV  = 4,
   parameter int BCLK_DIV  = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   output logic                         AC_MCLK,
   output logic                         AC_BCLK,
   output logic                         BCLK_Rise,
   output logic                         BCLK_Fall,
   output logic                         AC_LRCLK,
   output logic                         LRCLK_Rise,
   output logic                         LRCLK_Fall,
   output logic                         frame_start_o,
   output logic [$clog2(NUM_SLOTS)-1:0] slot_idx_o,
   output logic [$clog2(DATA_SIZE)-1:0] bit_idx_o,
   output logic                         busy_o
`ifdef STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN
   ,
   output logic [31:0]                  frame_cnt_o
`endif
);

   localparam int BH     = bclk_half(MCLK_DIV, BCLK_DIV);
   localparam int SLOT_W = $clog2(NUM_SLOTS);
   localparam int BIT_W  = $clog2(DATA_SIZE);
   localparam bit I2S_MODE = (NUM_SLOTS == 2);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

   state_e              state_q, state_d;
   logic                first_q, first_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                lr_q, lr_d;
   logic                lr_rise_q, lr_rise_d;
   logic                lr_fall_q, lr_fall_d;
   logic                fs_q, fs_d;
   logic                run, div_clr, bclk_tc, fall_next, frame_end;
   logic                mclk_tc_unused, mclk_rise_unused, mclk_fall_unused;

   assign run     = (state_q != ST_IDLE);
   assign div_clr = (state_d == ST_IDLE);

   student_clk_div_strobe #(.HALF(MCLK_DIV / 2)) u_mclk_div (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (div_clr),
      .en_i    (run),
      .tc_o    (mclk_tc_unused),
      .level_o (AC_MCLK),
      .rise_o  (mclk_rise_unused),
      .fall_o  (mclk_fall_unused)
   );

   student_clk_div_strobe #(.HALF(BH)) u_bclk_div (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (div_clr),
      .en_i    (run),
      .tc_o    (bclk_tc),
      .level_o (AC_BCLK),
      .rise_o  (BCLK_Rise),
      .fall_o  (BCLK_Fall)
   );

   // A BCLK fall lands on the next edge; the first one after IDLE opens a frame
   assign fall_next = bclk_tc && AC_BCLK;
   assign frame_end = fall_next && (first_q || (bit_q == BIT_LAST && slot_q == SLOT_LAST));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en_i) state_d = ST_RUN;
         ST_RUN:  if (!en_i) state_d = ST_STOP;
         ST_STOP: begin
            if (en_i)           state_d = ST_RUN;
            else if (frame_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      first_d = first_q;
      slot_d  = slot_q;
      bit_d   = bit_q;
      if (!run)
         first_d = 1'b1;
      else if (fall_next)
         first_d = 1'b0;

      if (state_d == ST_IDLE) begin
         slot_d = '0;
         bit_d  = '0;
      end else if (fall_next && !first_q) begin
         if (bit_q == BIT_LAST) begin
            bit_d  = '0;
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
         end else begin
            bit_d = bit_q + 1'b1;
         end
      end

      fs_d = frame_end && (state_d != ST_IDLE);

      // Stopping drops LRCLK silently, without a strobe
      if (state_d == ST_IDLE)
         lr_d = 1'b0;
      else if (I2S_MODE)
         lr_d = slot_d[0];
      else if (fall_next)
         lr_d = fs_d;
      else
         lr_d = lr_q;
      lr_rise_d = (state_d != ST_IDLE) && lr_d && !lr_q;
      lr_fall_d = (state_d != ST_IDLE) && !lr_d && lr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         first_q   <= 1'b1;
         slot_q    <= '0;
         bit_q     <= '0;
         lr_q      <= 1'b0;
         lr_rise_q <= 1'b0;
         lr_fall_q <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         first_q   <= first_d;
         slot_q    <= slot_d;
         bit_q     <= bit_d;
         lr_q      <= lr_d;
         lr_rise_q <= lr_rise_d;
         lr_fall_q <= lr_fall_d;
         fs_q      <= fs_d;
      end
   end

`ifdef STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN
   logic [31:0] fcnt_q, fcnt_d;

   // Counts alongside frame_start_o and holds through IDLE
   assign fcnt_d = fcnt_q + 32'(fs_d);

   always_ff @(posedge clk_i) begin
      if (rst_i) fcnt_q <= '0;
      else       fcnt_q <= fcnt_d;
   end

   assign frame_cnt_o = fcnt_q;
`endif

   assign AC_LRCLK      = lr_q;
   assign LRCLK_Rise    = lr_rise_q;
   assign LRCLK_Fall    = lr_fall_q;
   assign frame_start_o = fs_q;
   assign slot_idx_o    = slot_q;
   assign bit_idx_o     = bit_q;
   assign busy_o        = run;

endmodule

// File: tb/tb_student_tdm_clock_gen.sv
// Bench for student_tdm_clock_gen: an I2S instance (defaults) and a TDM instance
// checked every cycle against a time-based reference model, plus directed sequences.
module tb_student_tdm_clock_gen;

   localparam int A_DS = 16, A_NS = 2, A_MD = 4, A_BD = 2, A_BH = 4;
   localparam int B_DS = 32, B_NS = 8, B_MD = 2, B_BD = 1, B_BH = 1;

   localparam logic [31:0] M_B  = 32'h8000_0000;
   localparam logic [31:0] M_M  = 32'h4000_0000;
   localparam logic [31:0] M_C  = 32'h2000_0000;
   localparam logic [31:0] M_R  = 32'h1000_0000;
   localparam logic [31:0] M_F  = 32'h0800_0000;
   localparam logic [31:0] M_FS = 32'h0080_0000;

   localparam int W_FS_A = 0, W_IDLE_A = 1, W_BRISE_A = 2, W_LRR_A = 3;
   localparam int W_BIT5_A = 4, W_SLOT1_A = 5, W_FS_B = 6, W_IDLE_B = 7;

   logic clk, rst, en_a, en_b;
   logic mclk_a, bclk_a, br_a, bf_a, lr_a, lrr_a, lrf_a, fs_a, busy_a, slot_a;
   logic [3:0] bit_a;
   logic mclk_b, bclk_b, br_b, bf_b, lr_b, lrr_b, lrf_b, fs_b, busy_b;
   logic [2:0] slot_b;
   logic [4:0] bit_b;
`ifdef STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN
   logic [31:0] fc_a, fc_b;
`endif

   int nchk = 0, nfail = 0;
   bit chk_on = 1'b0;
   int sta = 0, ta = 0, stb = 0, tb_t = 0;
   logic [31:0] fca_m = '0, fcb_m = '0;

   student_tdm_clock_gen #(.DATA_SIZE(A_DS), .NUM_SLOTS(A_NS), .MCLK_DIV(A_MD), .BCLK_DIV(A_BD)) dut_a (
      .clk_i(clk), .rst_i(rst), .en_i(en_a),
      .AC_MCLK(mclk_a), .AC_BCLK(bclk_a), .BCLK_Rise(br_a), .BCLK_Fall(bf_a),
      .AC_LRCLK(lr_a), .LRCLK_Rise(lrr_a), .LRCLK_Fall(lrf_a), .frame_start_o(fs_a),
      .slot_idx_o(slot_a), .bit_idx_o(bit_a), .busy_o(busy_a)
`ifdef STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN
      , .frame_cnt_o(fc_a)
`endif
   );

   student_tdm_clock_gen #(.DATA_SIZE(B_DS), .NUM_SLOTS(B_NS), .MCLK_DIV(B_MD), .BCLK_DIV(B_BD)) dut_b (
      .clk_i(clk), .rst_i(rst), .en_i(en_b),
      .AC_MCLK(mclk_b), .AC_BCLK(bclk_b), .BCLK_Rise(br_b), .BCLK_Fall(bf_b),
      .AC_LRCLK(lr_b), .LRCLK_Rise(lrr_b), .LRCLK_Fall(lrf_b), .frame_start_o(fs_b),
      .slot_idx_o(slot_b), .bit_idx_o(bit_b), .busy_o(busy_b)
`ifdef STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN
      , .frame_cnt_o(fc_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: state (0 idle, 1 run, 2 stop) plus cycles t since busy rose
   function automatic bit is_fs(input int t, input int ds, input int ns, input int bh);
      return (t > 0) && (t % (2 * bh) == 0) && (((t / (2 * bh)) - 1) % (ds * ns) == 0);
   endfunction

   function automatic logic lr_at(input int t, input int ds, input int ns, input int bh);
      int k, p;
      k = t / (2 * bh);
      if (k == 0) return 1'b0;
      p = (k - 1) % (ds * ns);
      if (ns == 2) return ((p / ds) % 2) == 1;
      return p == 0;
   endfunction

   function automatic logic [31:0] mexp(input int st, input int t, input int ds, input int ns,
                                        input int md, input int bh);
      logic [31:0] v;
      logic lrp;
      int bp, k, p;
      v = '0;
      if (st == 0) return v;
      bp = 2 * bh;
      k = t / bp;
      p = (k > 0) ? (k - 1) % (ds * ns) : 0;
      lrp = (t > 0) ? lr_at(t - 1, ds, ns, bh) : 1'b0;
      v[31] = 1'b1;
      v[30] = ((t / (md / 2)) % 2) == 1;
      v[29] = ((t / bh) % 2) == 1;
      v[28] = (t % bp) == bh;
      v[27] = (t > 0) && (t % bp == 0);
      v[26] = lr_at(t, ds, ns, bh);
      v[25] = v[26] && !lrp;
      v[24] = !v[26] && lrp;
      v[23] = v[27] && (p == 0);
      v[15:8] = 8'(p / ds);
      v[7:0] = 8'(p % ds);
      return v;
   endfunction

   function automatic void model_next(input logic r, input logic e, input int st, input int t,
                                      input int ds, input int ns, input int bh,
                                      output int st_n, output int t_n);
      st_n = st;
      t_n = t;
      if (r) begin
         st_n = 0; t_n = 0;
      end else if (st == 0) begin
         if (e) begin st_n = 1; t_n = 0; end
      end else if (st == 2 && !e && is_fs(t + 1, ds, ns, bh)) begin
         st_n = 0; t_n = 0;
      end else begin
         st_n = e ? 1 : 2;
         t_n = t + 1;
      end
   endfunction

   always @(posedge clk) begin
      int s_n, t_n;
      logic [31:0] e;
      model_next(rst, en_a, sta, ta, A_DS, A_NS, A_BH, s_n, t_n);
      e = mexp(s_n, t_n, A_DS, A_NS, A_MD, A_BH);
      sta <= s_n;
      ta <= t_n;
      fca_m <= rst ? 32'd0 : fca_m + 32'(e[23]);
      model_next(rst, en_b, stb, tb_t, B_DS, B_NS, B_BH, s_n, t_n);
      e = mexp(s_n, t_n, B_DS, B_NS, B_MD, B_BH);
      stb <= s_n;
      tb_t <= t_n;
      fcb_m <= rst ? 32'd0 : fcb_m + 32'(e[23]);
   end

   function automatic logic [31:0] pk(input logic b, input logic m, input logic c, input logic r,
                                      input logic f, input logic l, input logic lr, input logic lf,
                                      input logic fs, input logic [7:0] sl, input logic [7:0] bi);
      return {b, m, c, r, f, l, lr, lf, fs, 7'b0, sl, bi};
   endfunction

   logic [31:0] pack_a, pack_b;
   assign pack_a = pk(busy_a, mclk_a, bclk_a, br_a, bf_a, lr_a, lrr_a, lrf_a, fs_a, 8'(slot_a), 8'(bit_a));
   assign pack_b = pk(busy_b, mclk_b, bclk_b, br_b, bf_b, lr_b, lrr_b, lrf_b, fs_b, 8'(slot_b), 8'(bit_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h (time %0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("cycle_a", pack_a, mexp(sta, ta, A_DS, A_NS, A_MD, A_BH));
         chk("cycle_b", pack_b, mexp(stb, tb_t, B_DS, B_NS, B_MD, B_BH));
`ifdef STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN
         chk("fcnt_a", fc_a, fca_m);
         chk("fcnt_b", fc_b, fcb_m);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic bit cond(input int w);
      case (w)
         W_FS_A:    return fs_a;
         W_IDLE_A:  return !busy_a;
         W_BRISE_A: return br_a;
         W_LRR_A:   return lrr_a;
         W_BIT5_A:  return (bit_a == 4'd5) && (slot_a == 1'b0);
         W_SLOT1_A: return slot_a == 1'b1;
         W_FS_B:    return fs_b;
         W_IDLE_B:  return !busy_b;
         default:   return 1'b0;
      endcase
   endfunction

   // Steps at least once; n = -1 when the bound expires
   task automatic run_until(input int w, input int lim, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!cond(w) && n < lim);
      if (!cond(w)) n = -1;
   endtask

   typedef struct {
      logic        rst;
      logic        en;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[21];
   logic [31:0] ramp[17];

   initial begin
      int n, n2, nfs, lowb, lc, ms;
      rst = 1'b1; en_a = 1'b0; en_b = 1'b0;

      ramp = '{M_B, M_B, M_B|M_M, M_B|M_M, M_B|M_C|M_R, M_B|M_C, M_B|M_C|M_M, M_B|M_C|M_M,
               M_B|M_F|M_FS, M_B, M_B|M_M, M_B|M_M, M_B|M_C|M_R, M_B|M_C, M_B|M_C|M_M,
               M_B|M_C|M_M, M_B|M_F|32'h1};
      for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, 1'b0, 32'h0};
      for (int i = 0; i < 17; i++) tbl[4 + i] = '{1'b0, 1'b1, ramp[i]};

      // Reset then start-up timing of the default instance, one row per cycle
      for (int i = 0; i < 21; i++) begin
         rst = tbl[i].rst;
         en_a = tbl[i].en;
         @(posedge clk);
         chk_on = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d", i), pack_a, tbl[i].exp);
      end

      run_until(W_FS_A, 600, n);
      chk("second_fs_delay", n, 248);
      run_until(W_LRR_A, 600, n);
      chk("lrclk_rise_after_fs", n, 128);
      run_until(W_FS_A, 600, n2);
      chk("lrclk_high_len", n2, 128);
      chk("lrclk_fall_at_fs", lrf_a, 1'b1);
      chk("fs_period", n + n2, 256);

      // Graceful stop from slot 0 bit 5
      run_until(W_BIT5_A, 600, n);
      chk("bit5_delay", n, 40);
      en_a = 1'b0;
      n = 0; nfs = 0;
      do begin
         step();
         n++;
         nfs += fs_a;
      end while (busy_a && n < 400);
      chk("stop_delay", n, 216);
      chk("stop_no_fs", nfs, 0);
      chk("stop_outputs_zero", pack_a, 32'h0);

      en_a = 1'b1;
      step();
      chk("restart_busy", busy_a, 1'b1);
      run_until(W_FS_A, 20, n);
      chk("restart_first_fs", n, 8);

      // Re-enable during STOP keeps frames uninterrupted
      n = 0; lowb = 0;
      do begin
         step();
         n++;
         if (n == 20) en_a = 1'b0;
         if (n == 50) en_a = 1'b1;
         if (!busy_a) lowb++;
      end while (!fs_a && n < 400);
      chk("reenable_period", n, 256);
      chk("reenable_busy_gap", lowb, 0);

      // en_i drops on the same edge as a frame-ending fall: one more frame follows
      for (int i = 0; i < 255; i++) step();
      en_a = 1'b0;
      step();
      chk("simul_fs", fs_a, 1'b1);
      run_until(W_IDLE_A, 600, n);
      chk("simul_extra_frame", n, 256);

      // Reset in the middle of slot 1
      en_a = 1'b1;
      step();
      run_until(W_SLOT1_A, 600, n);
      chk("slot1_delay", n, 136);
      rst = 1'b1;
      step();
      chk("midframe_reset", pack_a, 32'h0);
      rst = 1'b0;
      step();
      chk("post_reset_busy", busy_a, 1'b1);
      run_until(W_BRISE_A, 20, n);
      chk("post_reset_rise", n, 4);
      run_until(W_FS_A, 20, n);
      chk("post_reset_fs", n, 4);

      // TDM instance: 8 slots of 32 bits, BCLK period 2
      en_b = 1'b1;
      run_until(W_FS_B, 600, n);
      chk("tdm_first_fs", n, 3);
      n = 0; lc = int'(lr_b); ms = 0;
      do begin
         step();
         n++;
         if (!fs_b) lc += int'(lr_b);
         if (int'(slot_b) > ms) ms = int'(slot_b);
      end while (!fs_b && n < 1000);
      chk("tdm_period", n, 512);
      chk("tdm_lrclk_high", lc, 2);
      chk("tdm_max_slot", ms, 7);

      // Random enables and occasional resets against the model
      for (int c = 0; c < 8000; c++) begin
         if ($urandom_range(0, 149) == 0) en_a = ~en_a;
         if ($urandom_range(0, 299) == 0) en_b = ~en_b;
         rst = ($urandom_range(0, 1999) == 0);
         step();
      end
      rst = 1'b0;

`ifdef STUDENT_TDM_CLOCK_GEN_FRAME_CNT_EN
      rst = 1'b1; en_a = 1'b0;
      step();
      chk("fc_reset", fc_a, 32'd0);
      rst = 1'b0; en_a = 1'b1;
      for (int k = 0; k < 5; k++) run_until(W_FS_A, 600, n);
      chk("fc_five", fc_a, 32'd5);
      en_a = 1'b0;
      run_until(W_IDLE_A, 600, n);
      chk("fc_after_stop", fc_a, 32'd5);
      en_a = 1'b1;
      step();
      step();
      chk("fc_restart", fc_a, 32'd5);
      run_until(W_FS_A, 20, n);
      chk("fc_six", fc_a, 32'd6);
      rst = 1'b1;
      step();
      chk("fc_cleared", fc_a, 32'd0);
      rst = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
